// File: rtl/seq_approx_mult_pkg.sv
// Shared types and adder cells for the sequential approximate multiplier.
package seq_approx_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Exact full adder, returns {carry, sum}.
  function automatic logic [1:0] fa_exact(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  // Area-reduced cell: sum is an OR, carry ignores the accumulator bit.
  function automatic logic [1:0] fa_approx(input logic x, input logic y, input logic z);
    return {y & z, x | y | z};
  endfunction

endpackage

// File: rtl/seq_approx_mult_row.sv
// One 2*WIDTH ripple accumulation row; low APPROX_COLS columns can switch to
// approximate cells. The carry out of the top column is dropped.
module approx_acc_row
  import seq_approx_mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 6
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] pp_i,
  input  logic               approx_i,
  output logic [2*WIDTH-1:0] sum_o
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar k = 0; k < PW; k++) begin : g_col
    localparam bit IS_APX = (k < APPROX_COLS);
    logic use_apx;

    assign use_apx = IS_APX && approx_i;

    if (k < PW - 1) begin : g_mid
      logic [1:0] res;
      // Column cell selection: approximate only when enabled for this column.
      always_comb begin
        if (use_apx) res = fa_approx(acc_i[k], pp_i[k], carry[k]);
        else         res = fa_exact(acc_i[k], pp_i[k], carry[k]);
      end
      assign sum_o[k]     = res[0];
      assign carry[k + 1] = res[1];
    end else begin : g_top
      // Top column only needs the sum; its carry would be discarded anyway.
      assign sum_o[k] = use_apx ? (acc_i[k] | pp_i[k] | carry[k])
                                : (acc_i[k] ^ pp_i[k] ^ carry[k]);
    end
  end

endmodule

// File: rtl/seq_approx_mult.sv
// Iterative shift-add multiplier, one partial-product row per clock, behind a
// valid/ready handshake. Row timing is data-independent.
module seq_approx_mult
  import seq_approx_mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              approx_q;
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     acc_q;
  logic [PW-1:0]     pp;
  logic [PW-1:0]     row_sum;
  logic              accept;
  logic              last_row;

  assign accept   = in_valid && (state_q == IDLE);
  assign last_row = (cnt_q == CW'(WIDTH - 1));

  // Current shifted partial-product row selected by the iteration counter.
  always_comb begin
    pp = '0;
    if (b_q[cnt_q]) pp = {{WIDTH{1'b0}}, a_q} << cnt_q;
  end

  approx_acc_row #(
    .WIDTH      (WIDTH),
    .APPROX_COLS(APPROX_COLS)
  ) u_row (
    .acc_i   (acc_q),
    .pp_i    (pp),
    .approx_i(approx_q),
    .sum_o   (row_sum)
  );

  // Operand latch, accumulator and row counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
    end else if (accept) begin
      a_q      <= in_a;
      b_q      <= in_b;
      approx_q <= in_approx;
      cnt_q    <= '0;
      acc_q    <= '0;
    end else if (state_q == RUN) begin
      acc_q <= row_sum;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_row) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; product is only exposed while holding a result.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == RUN);
    out_valid = (state_q == DONE);
    out_p     = (state_q == DONE) ? acc_q : '0;
  end

endmodule

// File: tb/tb_seq_approx_mult.sv
module tb_seq_approx_mult;

  localparam int W = 8;
  localparam int N = 4;

  function automatic int ac_of(input int g);
    case (g)
      0:       return 0;
      1:       return 4;
      2:       return 6;
      default: return 16;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic in_approx = 1'b0;
  logic out_ready = 1'b0;

  logic [N-1:0] ir, ov, bz;
  logic [N-1:0][2*W-1:0] p;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    seq_approx_mult #(
      .WIDTH      (W),
      .APPROX_COLS(ac_of(g))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (ir[g]),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_approx(in_approx),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .out_p    (p[g]),
      .busy     (bz[g])
    );
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: OR of partial products in the low columns, exact sum of the
  // right-shifted partial products above them.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic apx, input int ac);
    logic [31:0] pp, orl, hi, mask;
    orl = '0;
    hi  = '0;
    if (!apx || ac == 0) return 16'(a * b);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        pp  = 32'(a) << i;
        orl = orl | pp;
        hi  = hi + (pp >> ac);
      end
    end
    mask = (32'd1 << ac) - 32'd1;
    return 16'((hi << ac) | (orl & mask));
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic apx,
                        input int exp6, input int exp16, input int hold);
    int n;
    @(negedge clk);
    chk("in_ready_idle", ir[2], 1);
    in_a = a; in_b = b; in_approx = apx; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("busy_run", bz[2], 1);
    chk("in_ready_run", ir[2], 0);
    n = 0;
    while (!ov[2] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 8);
    chk("busy_done", bz[2], 0);
    for (int g = 0; g < N; g++) chk($sformatf("model_ac%0d", ac_of(g)), p[g], model(a, b, apx, ac_of(g)));
    if (exp6 >= 0)  chk("hand_ac6", p[2], exp6);
    if (exp16 >= 0) chk("hand_ac16", p[3], exp16);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_valid", ov[2], 1);
      chk("hold_in_ready", ir[2], 0);
      chk("hold_p", p[2], exp6);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("retire_valid", ov[2], 0);
    chk("retire_in_ready", ir[2], 1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       apx;
    int         exp6;
    int         exp16;
  } vec_t;

  initial begin
    vec_t tbl[$];
    tbl.push_back('{8'd255, 8'd255, 1'b0, 65025, 65025});
    tbl.push_back('{8'd255, 8'd255, 1'b1, 64767, 32767});
    tbl.push_back('{8'd3,   8'd3,   1'b1, 7,     7});
    tbl.push_back('{8'd3,   8'd3,   1'b0, 9,     9});
    tbl.push_back('{8'd12,  8'd10,  1'b0, 120,   120});
    tbl.push_back('{8'd12,  8'd10,  1'b1, 120,   120});
    tbl.push_back('{8'd0,   8'd200, 1'b1, 0,     0});
    tbl.push_back('{8'd200, 8'd0,   1'b0, 0,     0});
    tbl.push_back('{8'd1,   8'd1,   1'b1, 1,     1});
    tbl.push_back('{8'd128, 8'd128, 1'b0, 16384, 16384});
    tbl.push_back('{8'd128, 8'd128, 1'b1, 16384, 16384});
    tbl.push_back('{8'd5,   8'd3,   1'b1, 15,    15});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", ir[2], 1);
    chk("rst_out_valid", ov[2], 0);
    chk("rst_out_p", p[2], 0);
    chk("rst_busy", bz[2], 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].apx, tbl[i].exp6, tbl[i].exp16, 0);

    // Backpressure: result held for five cycles, stray in_valid ignored.
    run_op(8'd12, 8'd10, 1'b0, 120, 120, 5);

    // Reset while counter is at 3.
    @(negedge clk);
    in_a = 8'd100; in_b = 8'd100; in_approx = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", bz[2], 1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", ov[2], 0);
    chk("midrst_out_p", p[2], 0);
    chk("midrst_in_ready", ir[2], 1);
    chk("midrst_busy", bz[2], 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'd7, 8'd6, 1'b0, 42, 42, 0);

    // Reset while holding a result.
    @(negedge clk);
    in_a = 8'd9; in_b = 8'd9; in_approx = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_done", ov[2], 1);
    rst = 1'b1;
    #1;
    chk("donerst_out_valid", ov[2], 0);
    chk("donerst_out_p", p[2], 0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 300; r++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), -1, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
